// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits,
// paced by the shared 16x baud tick. Define UART_TX_BREAK_EN to add the tx_break input.
module uart_tx_core #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud16_en,
  input  logic [1:0] cfg_data_bits,
  input  logic       cfg_parity_en,
  input  logic       cfg_parity_odd,
  input  logic       cfg_stop2,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
`ifdef UART_TX_BREAK_EN
  input  logic       tx_break,
`endif
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK,
    S_MARK
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    nbits_q, nbits_d;
  logic          par_en_q, par_en_d;
  logic          par_odd_q, par_odd_d;
  logic          stop2_q, stop2_d;
  logic          serial_q, serial_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          bit_end;
  logic [2:0]    last_idx;
  logic          parity_bit;

  assign bit_end    = baud16_en && (tick_q == TICK_LAST);
  // N-1 for N = 5..8 is simply the 2-bit code with a leading one.
  assign last_idx   = {1'b1, nbits_q};
  assign parity_bit = (^(data_q & (8'hFF >> ~nbits_q))) ^ par_odd_q;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    data_d    = data_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    done_d    = 1'b0;

    if (state_q != S_IDLE && baud16_en) begin
      tick_d = tick_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        idx_d  = '0;
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          state_d = S_BREAK;
        end else
`endif
        if (tx_start) begin
          state_d   = S_START;
          data_d    = tx_data;
          nbits_d   = cfg_data_bits;
          par_en_d  = cfg_parity_en;
          par_odd_d = cfg_parity_odd;
          stop2_d   = cfg_stop2;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == last_idx) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        // idx counts stop bits so the second stop bit reuses the same tick counter.
        if (bit_end) begin
          if (stop2_q && idx_q == 3'd0) begin
            idx_d = 3'd1;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (!tx_break) begin
          state_d = S_MARK;
          tick_d  = '0;
          idx_d   = '0;
        end
      end
      S_MARK: begin
        if (bit_end) begin
          if (idx_q == 3'd0) begin
            idx_d = 3'd1;
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line level is decoded from the next state so tx_serial stays a plain flop.
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = data_d[idx_d];
      S_PARITY: serial_d = parity_bit;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  serial_d = 1'b0;
`endif
      default:  serial_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Serial transmitter that pairs with the existing UART receive path inside tt_um_uart.
- Takes a parallel byte plus a frame-format configuration and serialises it LSB-first onto a single line.
- Frame: start bit, 5–8 data bits, optional even/odd parity, 1 or 2 stop bits.
- Bit timing comes from the shared 16x-oversample baud enable (baud16_en), so the receiver and this block run off one baud generator.

Parameters:
OVERSAMPLE, 16, baud16_en ticks per bit; must be a power of two, from 4 to 16.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
baud16_en  input  1  one-cycle-wide tick at 16x baud; bit timing advances only on these ticks
cfg_data_bits  input  2  data length: 00=5, 01=6, 10=7, 11=8
cfg_parity_en  input  1  1 = append parity bit
cfg_parity_odd  input  1  parity sense when enabled: 1=odd, 0=even
cfg_stop2  input  1  1 = two stop bits, 0 = one
tx_data  input  8  byte to send; bits above the configured length are ignored
tx_start  input  1  request; accepted only when tx_busy=0
tx_serial  output  1  serial line; idles high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset (rst_n=0 at a clk edge): tx_serial=1, tx_busy=0, tx_done=0, FSM=IDLE, tick counter=0, bit index=0.
- Reset mid-frame aborts the frame. The line returns high at that edge; no tx_done pulse.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_start=1 and tx_busy=0 at an edge: latch tx_data, cfg_data_bits, cfg_parity_en, cfg_parity_odd, cfg_stop2.
  - At that same edge: clear the tick counter, move to START, set tx_busy=1, drive tx_serial=0.
  - Latency from start to line-low is one clock.
- Config and data are used only as latched. Input changes during a frame have no effect.
- Bit timing:
  - Every state except IDLE counts baud16_en ticks.
  - On the OVERSAMPLE-th tick, the state advances and the counter wraps to 0.
  - Each bit therefore lasts exactly OVERSAMPLE ticks. The start bit's first tick phase is whatever tick follows acceptance.
  - baud16_en held low freezes the FSM and the line indefinitely.
- START: drive 0. After OVERSAMPLE ticks, go to DATA with bit index 0.
- DATA:
  - Drive latched data[index], LSB first.
  - After OVERSAMPLE ticks, if index = N-1 (N = 5..8), go to PARITY when parity is enabled, otherwise to STOP. Else increment index.
- PARITY:
  - Drive p = XOR of the N data bits, inverted when parity is odd.
  - Even: the total count of ones in data+parity is even. Odd: the total count is odd.
  - After OVERSAMPLE ticks, go to STOP.
- STOP:
  - Drive 1 for OVERSAMPLE ticks, or 2×OVERSAMPLE ticks when cfg_stop2 is latched.
  - On the final tick edge: go to IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- tx_start in the cycle that tx_done is asserted: accepted, because tx_busy is already 0. START begins at that edge, giving back-to-back frames with no idle gap.
- tx_start while tx_busy=1: ignored and not queued.
- Frame length in ticks = OVERSAMPLE × (1 + N + parity_en + 1 + stop2).
- All outputs are registered; no combinational path from any input to tx_serial.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input port tx_break (1 bit).
  - In IDLE with tx_break=1, tx_serial is driven 0 and tx_busy=1. No frame is sent while break is held.
  - On release, the line returns to 1 and the block stays busy for 2×OVERSAMPLE ticks of mark before returning to IDLE.
  - tx_break during a frame is ignored until the frame completes.
- Not defined: no tx_break port; behaviour is exactly as above.

Test Plan:
1. 8N1, tx_data=0xA5, one tx_start pulse -> tx_serial sequence 0,1,0,1,0,0,1,0,1,1, each held 16 ticks. tx_busy high for 160 ticks, then one tx_done pulse.
2. 8 bits odd parity, 1 stop, tx_data=0xAA -> data bits 0,1,0,1,0,1,0,1, parity bit 1; 176 ticks total. The same frame with even parity -> parity bit 0.
3. 5 bits even parity, 2 stop, tx_data=0xFF -> line 0,1,1,1,1,1, parity 1, stop 1,1 (144 ticks); upper three data bits never appear on the line.
4. tx_start re-pulsed mid-frame with tx_data=0x00 -> ignored; the original frame is unchanged. A tx_start asserted in the tx_done cycle with 0x3C -> second start bit begins at that edge.
5. rst_n=0 for one cycle during DATA bit 3 -> next edge tx_serial=1, tx_busy=0, no tx_done. baud16_en held 0 for 1000 cycles mid-frame -> line and state frozen, then resume with correct remaining timing.
6. (UART_TX_BREAK_EN) tx_break=1 for 40 ticks in IDLE -> line low 40 ticks, then high with tx_busy=1 for 32 ticks, then tx_busy=0.
